// File: rtl/picomips_io_pkg.sv
// picomips_io_pkg
//   Shared types and default sizes for the picoMIPS board-side operator I/O.
//   hs_state_t enumerates the handshake walked by sw_handshake_if:
//   capture x1, capture y1, start the core, show x2, show y2, repeat.
package picomips_io_pkg;

  localparam int DW_DEF          = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CNT_DEF      = 3;

  typedef enum logic [2:0] {
    WAIT0_X = 3'd0,
    WAIT1_X = 3'd1,
    WAIT0_Y = 3'd2,
    WAIT1_Y = 3'd3,
    WAIT0_C = 3'd4,
    CALC    = 3'd5,
    SHOW_X2 = 3'd6,
    SHOW_Y2 = 3'd7
  } hs_state_t;

endpackage

// File: rtl/bstus_filter.sv
// bstus_filter
//   Synchroniser plus debounce filter for one asynchronous operator switch.
//   The filtered level only changes after DB_CNT consecutive synchronised
//   samples disagree with it, so pulses shorter than DB_CNT cycles vanish.
//   Input edge to level change: SYNC_STAGES + DB_CNT cycles.
// Ports
//   fastclk : system clock
//   nreset  : synchronous active-low reset
//   din     : asynchronous switch input
//   level   : filtered switch level
//   rise    : one-cycle pulse, high in the first cycle level reads 1
//   fall    : one-cycle pulse, high in the first cycle level reads 0
module bstus_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 3
) (
  input  logic fastclk,
  input  logic nreset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // Counter only needs to reach DB_CNT-1; the toggle happens on the next hit.
  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_bst_s;
  logic                   w_cnt_done;

  assign w_bst_s    = r_sync[SYNC_STAGES-1];
  assign w_cnt_done = (r_cnt == CW'(DB_CNT - 1));

  always_ff @(posedge fastclk) begin
    if (!nreset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge fastclk) begin
    if (!nreset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_bst_s != r_level) begin
        if (w_cnt_done) begin
          r_level <= w_bst_s;
          r_cnt   <= '0;
          r_rise  <= w_bst_s;
          r_fall  <= ~w_bst_s;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        // Any agreeing sample restarts the stability window.
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/sw_handshake_if.sv
// sw_handshake_if
//   Board-side receiver for the Bstus/SW/LED operator protocol of picoMIPS.
//   Walks: wait 0, wait 1, capture x1; wait 0, wait 1, capture y1; wait 0,
//   start core; show x2; wait 1, show y2; wait 0, repeat.
// Ports
//   fastclk   : system clock (50 MHz)
//   nreset    : synchronous active-low reset
//   Bstus     : operator handshake switch (SW[8]), asynchronous
//   SW        : operator data switches, asynchronous
//   LED       : result display (registered)
//   x1, y1    : captured operands for the core
//   start     : one-cycle compute request to the core
//   res_valid : one-cycle core result strobe
//   x2, y2    : core results, valid with res_valid
//   busy      : high from start until the result is accepted
module sw_handshake_if
  import picomips_io_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CNT      = DB_CNT_DEF
) (
  input  logic          fastclk,
  input  logic          nreset,
  input  logic          Bstus,
  input  logic [DW-1:0] SW,
  output logic [DW-1:0] LED,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] y1,
  output logic          start,
  input  logic          res_valid,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] y2,
  output logic          busy
);

  hs_state_t     r_state;
  hs_state_t     w_state_nxt;
  logic [DW-1:0] r_sw_sync [SYNC_STAGES];
  logic [DW-1:0] r_x1;
  logic [DW-1:0] r_y1;
  logic [DW-1:0] r_x2;
  logic [DW-1:0] r_y2;
  logic [DW-1:0] r_led;
  logic          r_busy;
  logic          w_bst_f;
  logic          w_rise;
  logic          w_fall;
  logic          w_start;
  logic          w_cap_x;
  logic          w_cap_y;
  logic          w_take_res;
  logic [DW-1:0] w_sw_s;

  bstus_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CNT      (DB_CNT)
  ) u_bstus_filter (
    .fastclk (fastclk),
    .nreset  (nreset),
    .din     (Bstus),
    .level   (w_bst_f),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  // SW is only sampled on a filtered Bstus rise, long after it settled, so a
  // plain per-bit synchroniser is enough here.
  always_ff @(posedge fastclk) begin
    if (!nreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= '0;
      end
    end else begin
      r_sw_sync[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= r_sw_sync[i-1];
      end
    end
  end

  assign w_sw_s = r_sw_sync[SYNC_STAGES-1];

  always_ff @(posedge fastclk) begin
    if (!nreset) begin
      r_state <= WAIT0_X;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cap_x     = 1'b0;
    w_cap_y     = 1'b0;
    w_take_res  = 1'b0;
    case (r_state)
      WAIT0_X: if (!w_bst_f) w_state_nxt = WAIT1_X;
      WAIT1_X: if (w_rise) begin
        w_cap_x     = 1'b1;
        w_state_nxt = WAIT0_Y;
      end
      WAIT0_Y: if (!w_bst_f) w_state_nxt = WAIT1_Y;
      WAIT1_Y: if (w_rise) begin
        w_cap_y     = 1'b1;
        w_state_nxt = WAIT0_C;
      end
      // start is combinational so the core sees it in the same cycle the
      // transition is taken; a result one cycle later lands in CALC.
      WAIT0_C: if (!w_bst_f) begin
        w_start     = 1'b1;
        w_state_nxt = CALC;
      end
      CALC: if (res_valid) begin
        w_take_res  = 1'b1;
        w_state_nxt = SHOW_X2;
      end
      SHOW_X2: if (w_rise) w_state_nxt = SHOW_Y2;
      // SHOW_Y2 is entered with level high, so the fall pulse marks the
      // first cycle of level low.
      SHOW_Y2: if (w_fall) w_state_nxt = WAIT1_X;
      default: w_state_nxt = WAIT0_X;
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (!nreset) begin
      r_x1   <= '0;
      r_y1   <= '0;
      r_x2   <= '0;
      r_y2   <= '0;
      r_led  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_cap_x) r_x1 <= w_sw_s;
      if (w_cap_y) r_y1 <= w_sw_s;
      if (w_take_res) begin
        r_x2 <= x2;
        r_y2 <= y2;
      end
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_take_res) begin
        r_busy <= 1'b0;
      end
      // Display follows the current state, one cycle behind it.
      case (r_state)
        SHOW_X2: r_led <= r_x2;
        SHOW_Y2: r_led <= r_y2;
        default: r_led <= '0;
      endcase
    end
  end

  assign LED   = r_led;
  assign x1    = r_x1;
  assign y1    = r_y1;
  assign start = w_start;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sw_handshake_if.sv
module tb_sw_handshake_if;
  import picomips_io_pkg::*;

  logic       fastclk = 1'b0;
  logic       nreset;
  logic       Bstus;
  logic [7:0] SW;
  logic [7:0] LED;
  logic [7:0] x1;
  logic [7:0] y1;
  logic       start;
  logic       res_valid;
  logic [7:0] x2;
  logic [7:0] y2;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;

  always #5 fastclk = ~fastclk;

  sw_handshake_if #(.DW(8), .SYNC_STAGES(2), .DB_CNT(3)) dut (
    .fastclk   (fastclk),
    .nreset    (nreset),
    .Bstus     (Bstus),
    .SW        (SW),
    .LED       (LED),
    .x1        (x1),
    .y1        (y1),
    .start     (start),
    .res_valid (res_valid),
    .x2        (x2),
    .y2        (y2),
    .busy      (busy)
  );

  always @(posedge fastclk) if (start === 1'b1) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  task automatic wait_led(input string tag, input logic [7:0] exp, input int budget);
    for (int i = 0; i < budget && LED !== exp; i++) tick(1);
    chk(tag, LED, exp);
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 30 && start !== 1'b1; i++) tick(1);
    chk(tag, start, 1);
  endtask

  // Core stub: answer dly cycles after start with the given results.
  task automatic core_reply(input int dly, input logic [7:0] a, input logic [7:0] b);
    wait_start("start_seen");
    tick(1);
    chk("busy_set", busy, 1);
    chk("start_one_cycle", start, 0);
    chk("state_calc", 32'(dut.r_state), 32'(CALC));
    tick(dly - 1);
    res_valid = 1'b1; x2 = a; y2 = b;
    tick(1);
    res_valid = 1'b0; x2 = 8'h00; y2 = 8'h00;
  endtask

  initial begin
    nreset = 1'b0; Bstus = 1'b1; SW = 8'hFF;
    res_valid = 1'b0; x2 = 8'h00; y2 = 8'h00;

    // 1: reset
    tick(5);
    chk("rst_led", LED, 0);
    chk("rst_x1", x1, 0);
    chk("rst_y1", y1, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", 32'(dut.r_state), 32'(WAIT0_X));

    // 2: operand capture
    nreset = 1'b1; Bstus = 1'b0;
    tick(8);
    chk("st_wait1x", 32'(dut.r_state), 32'(WAIT1_X));
    SW = 8'h04; Bstus = 1'b1;
    tick(5);
    chk("x1_not_early", x1, 0);
    tick(1);
    chk("x1_cap", x1, 8'h04);
    tick(4);
    Bstus = 1'b0;
    tick(8);
    chk("st_wait1y", 32'(dut.r_state), 32'(WAIT1_Y));
    SW = 8'h08; Bstus = 1'b1;
    tick(6);
    chk("y1_cap", y1, 8'h08);
    chk("x1_hold", x1, 8'h04);
    chk("st_wait0c", 32'(dut.r_state), 32'(WAIT0_C));
    chk("no_start_yet", n_start, 0);
    tick(4);

    // 3: compute and display
    Bstus = 1'b0;
    core_reply(3, 8'h0C, 8'h20);
    chk("busy_clr", busy, 0);
    chk("led_before", LED, 0);
    tick(1);
    chk("led_x2", LED, 8'h0C);
    chk("start_count", n_start, 1);
    Bstus = 1'b1;
    wait_led("led_y2", 8'h20, 12);
    chk("st_showy2", 32'(dut.r_state), 32'(SHOW_Y2));
    Bstus = 1'b0;
    wait_led("led_off", 8'h00, 12);
    chk("st_back_w1x", 32'(dut.r_state), 32'(WAIT1_X));

    // 4: glitch rejection
    SW = 8'h55;
    tick(4);
    Bstus = 1'b1; tick(1); Bstus = 1'b0; tick(8);
    Bstus = 1'b1; tick(2); Bstus = 1'b0; tick(8);
    chk("glitch_x1", x1, 8'h04);
    chk("glitch_state", 32'(dut.r_state), 32'(WAIT1_X));
    Bstus = 1'b1; tick(4); Bstus = 1'b0;
    tick(10);
    chk("pulse4_x1", x1, 8'h55);
    chk("pulse4_state", 32'(dut.r_state), 32'(WAIT1_Y));

    // 5: spurious result outside CALC
    res_valid = 1'b1; x2 = 8'hAA; y2 = 8'hBB;
    tick(1);
    res_valid = 1'b0; x2 = 8'h00; y2 = 8'h00;
    tick(2);
    chk("spur_state", 32'(dut.r_state), 32'(WAIT1_Y));
    chk("spur_busy", busy, 0);
    SW = 8'h66; Bstus = 1'b1;
    tick(10);
    chk("y1_cap2", y1, 8'h66);
    Bstus = 1'b0;
    core_reply(2, 8'h11, 8'h22);
    tick(1);
    chk("led_genuine_x2", LED, 8'h11);
    Bstus = 1'b1;
    wait_led("led_genuine_y2", 8'h22, 12);
    Bstus = 1'b0;
    wait_led("led_off2", 8'h00, 12);

    // 6: reset during CALC
    SW = 8'h01; Bstus = 1'b1; tick(10); Bstus = 1'b0; tick(10);
    SW = 8'h02; Bstus = 1'b1; tick(10); Bstus = 1'b0;
    wait_start("start_seen2");
    tick(1);
    chk("calc_busy", busy, 1);
    nreset = 1'b0;
    tick(1);
    nreset = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_led", LED, 0);
    chk("mid_rst_state", 32'(dut.r_state), 32'(WAIT0_X));
    chk("mid_rst_x1", x1, 0);
    res_valid = 1'b1; x2 = 8'h77; y2 = 8'h77;
    tick(1);
    res_valid = 1'b0; x2 = 8'h00; y2 = 8'h00;
    tick(3);
    chk("post_rst_state", 32'(dut.r_state), 32'(WAIT1_X));
    chk("post_rst_led", LED, 0);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
